// File: rtl/tagged_pair_packer.sv
// Strips the tag from 4-bit tagged codes, packs the 2-bit payloads MSB-first into bytes
// and queues each finished byte with its framing (last, pair count) in a small output FIFO.
//
// state | meaning
// P0    | no pairs collected, next pair lands in [7:6]
// P1    | one pair collected, next pair lands in [5:4]
// P2    | two pairs collected, next pair lands in [3:2]
// P3    | three pairs collected, next pair lands in [1:0] and closes the byte
module tagged_pair_packer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_code,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_byte,
    output logic       out_last,
    output logic [2:0] out_npairs,
    output logic       err
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [1:0] TAG_DATA = 2'b10;
    localparam logic [1:0] TAG_LAST = 2'b11;

    typedef enum logic [1:0] {
        P0 = 2'd0,
        P1 = 2'd1,
        P2 = 2'd2,
        P3 = 2'd3
    } cnt_t;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [2:0] npairs;
    } entry_t;

    cnt_t          cnt_q, cnt_d, cnt_next;
    logic [7:0]    acc_q, acc_d;
    logic          err_q, err_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    entry_t        mem_q [FIFO_DEPTH];
    entry_t        mem_d [FIFO_DEPTH];

    logic [1:0] tag;
    logic [1:0] pair;
    logic       accept;
    logic       pop;
    logic       push;
    entry_t     push_entry;
    logic [7:0] ins_byte;

    assign tag  = in_code[3:2];
    assign pair = in_code[1:0];

    // Readiness comes only from the registered occupancy, so out_ready never reaches in_ready.
    assign in_ready  = (count_q != CW'(FIFO_DEPTH));
    assign out_valid = (count_q != '0);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        ins_byte = acc_q;
        case (cnt_q)
            P0:      ins_byte[7:6] = pair;
            P1:      ins_byte[5:4] = pair;
            P2:      ins_byte[3:2] = pair;
            default: ins_byte[1:0] = pair;
        endcase
    end

    always_comb begin
        cnt_next = P0;
        case (cnt_q)
            P0:      cnt_next = P1;
            P1:      cnt_next = P2;
            P2:      cnt_next = P3;
            default: cnt_next = P0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= P0;
            acc_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            err_q <= err_d;
        end
    end

    // Illegal tags complete the handshake but leave acc/cnt untouched.
    always_comb begin
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        err_d      = err_q;
        push       = 1'b0;
        push_entry = '0;
        if (accept) begin
            case (tag)
                TAG_DATA: begin
                    if (cnt_q == P3) begin
                        push              = 1'b1;
                        push_entry.data   = ins_byte;
                        push_entry.last   = 1'b0;
                        push_entry.npairs = 3'd4;
                        cnt_d             = P0;
                        acc_d             = '0;
                    end else begin
                        acc_d = ins_byte;
                        cnt_d = cnt_next;
                    end
                end
                TAG_LAST: begin
                    push              = 1'b1;
                    push_entry.data   = ins_byte;
                    push_entry.last   = 1'b1;
                    push_entry.npairs = {1'b0, cnt_q} + 3'd1;
                    cnt_d             = P0;
                    acc_d             = '0;
                end
                default: begin
                    err_d = 1'b1;
                end
            endcase
        end
    end

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push) - CW'(pop);
        if (push) begin
            mem_d[wr_ptr_q] = push_entry;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            mem_q    <= mem_d;
        end
    end

    assign out_byte   = mem_q[rd_ptr_q].data;
    assign out_last   = mem_q[rd_ptr_q].last;
    assign out_npairs = mem_q[rd_ptr_q].npairs;
    assign err        = err_q;

endmodule

// File: tb/tb_tagged_pair_packer.sv
// Bench for tagged_pair_packer: directed scenarios plus random traffic, checked against
// a pair-list / byte-queue reference model.
module tb_tagged_pair_packer;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_code = 4'h0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_byte;
    logic       out_last;
    logic [2:0] out_npairs;
    logic       err;

    tagged_pair_packer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_byte   (out_byte),
        .out_last   (out_last),
        .out_npairs (out_npairs),
        .err        (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] b;
        logic       last;
        logic [2:0] np;
    } ent_t;

    ent_t       exp_q[$];
    logic [1:0] cur[$];
    logic       m_err = 1'b0;
    int         n_chk = 0;
    int         n_err = 0;
    int         n_acc = 0;
    int         n_pop = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic ent_t close_pkt(input logic last);
        ent_t e;
        e.b = 8'h00;
        for (int i = 0; i < cur.size(); i++) begin
            e.b = e.b | (8'(cur[i]) << (6 - 2 * i));
        end
        e.np   = 3'(cur.size());
        e.last = last;
        cur.delete();
        return e;
    endfunction

    // Called at posedge+1; drives inputs, checks outputs against the model, then advances one edge.
    task automatic cycle(input logic v, input logic [3:0] c, input logic r);
        bit acc;
        bit pop;
        in_valid  = v;
        in_code   = c;
        out_ready = r;
        #2;
        chk("in_ready", 32'(in_ready), 32'(exp_q.size() < DEPTH));
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        chk("err", 32'(err), 32'(m_err));
        if (exp_q.size() != 0) begin
            chk("out_byte", 32'(out_byte), 32'(exp_q[0].b));
            chk("out_last", 32'(out_last), 32'(exp_q[0].last));
            chk("out_npairs", 32'(out_npairs), 32'(exp_q[0].np));
        end
        acc = v && (exp_q.size() < DEPTH);
        pop = r && (exp_q.size() != 0);
        @(posedge clk);
        #1;
        if (pop) begin
            void'(exp_q.pop_front());
            n_pop++;
        end
        if (acc) begin
            n_acc++;
            case (c[3:2])
                2'b10: begin
                    cur.push_back(c[1:0]);
                    if (cur.size() == 4) exp_q.push_back(close_pkt(1'b0));
                end
                2'b11: begin
                    cur.push_back(c[1:0]);
                    exp_q.push_back(close_pkt(1'b1));
                end
                default: m_err = 1'b1;
            endcase
        end
    endtask

    task automatic drain();
        repeat (DEPTH + 2) cycle(1'b0, 4'h0, 1'b1);
    endtask

    task automatic fill_data(input int n);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, {2'b10, 2'($urandom_range(0, 3))}, 1'b0);
        end
    endtask

    int acc0;
    int pop0;

    initial begin
        #12;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_byte", 32'(out_byte), 32'h00);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_npairs", 32'(out_npairs), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        cycle(1'b1, 4'b1001, 1'b0);
        cycle(1'b1, 4'b1010, 1'b0);
        cycle(1'b1, 4'b1011, 1'b0);
        cycle(1'b1, 4'b1000, 1'b0);
        cycle(1'b0, 4'h0, 1'b0);
        chk("tp1_byte", 32'(out_byte), 32'h6C);
        chk("tp1_last", 32'(out_last), 32'd0);
        chk("tp1_npairs", 32'(out_npairs), 32'd4);
        drain();

        cycle(1'b1, 4'b1001, 1'b0);
        cycle(1'b1, 4'b1111, 1'b0);
        chk("tp2_byte", 32'(out_byte), 32'h70);
        chk("tp2_last", 32'(out_last), 32'd1);
        chk("tp2_npairs", 32'(out_npairs), 32'd2);
        drain();
        cycle(1'b1, 4'b1110, 1'b0);
        chk("tp2b_byte", 32'(out_byte), 32'h80);
        chk("tp2b_last", 32'(out_last), 32'd1);
        chk("tp2b_npairs", 32'(out_npairs), 32'd1);
        drain();

        fill_data(16);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        cycle(1'b1, 4'b1101, 1'b0);
        cycle(1'b1, 4'b1101, 1'b1);
        chk("pop_in_ready", 32'(in_ready), 32'd1);
        cycle(1'b1, 4'b1101, 1'b0);
        drain();

        fill_data(16);
        acc0 = n_acc;
        pop0 = n_pop;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, {2'b11, 2'($urandom_range(0, 3))}, 1'b1);
        end
        chk("sustain_acc", 32'(n_acc - acc0), 32'd19);
        chk("sustain_pop", 32'(n_pop - pop0), 32'd20);
        drain();

        cycle(1'b1, 4'b1001, 1'b0);
        cycle(1'b1, 4'b0110, 1'b0);
        chk("err_rise", 32'(err), 32'd1);
        cycle(1'b1, 4'b1111, 1'b0);
        chk("err_sticky", 32'(err), 32'd1);
        chk("err_byte", 32'(out_byte), 32'h70);
        chk("err_npairs", 32'(out_npairs), 32'd2);
        chk("err_last", 32'(out_last), 32'd1);
        drain();

        for (int i = 0; i < 400; i++) begin
            logic [1:0] t;
            t = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
            cycle(1'($urandom_range(0, 3) != 0), {t, 2'($urandom_range(0, 3))},
                  1'($urandom_range(0, 2) != 0));
        end
        drain();

        cycle(1'b1, 4'b1001, 1'b0);
        cycle(1'b1, 4'b1010, 1'b0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mrst_in_ready", 32'(in_ready), 32'd1);
        chk("mrst_out_valid", 32'(out_valid), 32'd0);
        chk("mrst_out_byte", 32'(out_byte), 32'h00);
        chk("mrst_out_last", 32'(out_last), 32'd0);
        chk("mrst_out_npairs", 32'(out_npairs), 32'd0);
        chk("mrst_err", 32'(err), 32'd0);
        exp_q.delete();
        cur.delete();
        m_err = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk);
        #1;
        cycle(1'b1, 4'b1111, 1'b0);
        cycle(1'b0, 4'h0, 1'b0);
        chk("mrst_byte", 32'(out_byte), 32'hC0);
        chk("mrst_npairs", 32'(out_npairs), 32'd1);
        chk("mrst_last", 32'(out_last), 32'd1);
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
